// File: rtl/regfile_sequencer.sv
// Bulk LOAD/DUMP engine driving the 32x32 register file write port
// and one combinational read port from valid/ready streams.
module regfile_sequencer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dump,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W-1:0] cmd_count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              rf_write_en,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0] rf_write_data,
  output logic [ADDR_W-1:0] rf_read_addr,
  input  logic [DATA_W-1:0] rf_read_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DUMP,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic              ov_q, ov_d;
  logic [DATA_W-1:0] od_q, od_d;
  logic [ADDR_W-1:0] oa_q, oa_d;

  logic cmd_acc;
  logic load_acc;
  logic out_load;
  logic drain_ack;
  logic last;

  assign cmd_acc   = (state_q == S_IDLE) & cmd_valid;
  assign load_acc  = (state_q == S_LOAD) & in_valid;
  // Output register refills when empty or when its word is taken.
  assign out_load  = (state_q == S_DUMP) & (~ov_q | out_ready);
  assign drain_ack = (state_q == S_DRAIN) & out_ready;
  assign last      = (rem_q == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      oa_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      oa_q    <= oa_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d = cmd_dump ? S_DUMP : S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_valid && last) begin
          state_d = S_DONE;
        end
      end
      S_DUMP: begin
        if (out_load && last) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    rem_d = rem_q;
    ov_d  = ov_q;
    od_d  = od_q;
    oa_d  = oa_q;
    if (cmd_acc) begin
      ptr_d = cmd_base;
      rem_d = cmd_count;
    end
    // Pointer wraps naturally at the address width.
    if (load_acc || out_load) begin
      ptr_d = ptr_q + ADDR_W'(1);
      if (!last) begin
        rem_d = rem_q - ADDR_W'(1);
      end
    end
    if (out_load) begin
      ov_d = 1'b1;
      od_d = rf_read_data;
      oa_d = ptr_q;
    end
    if (drain_ack) begin
      ov_d = 1'b0;
    end
  end

  always_comb begin
    cmd_ready     = (state_q == S_IDLE);
    in_ready      = (state_q == S_LOAD);
    busy          = (state_q != S_IDLE);
    done          = (state_q == S_DONE);
    rf_write_en   = load_acc;
    rf_write_addr = ptr_q;
    rf_write_data = in_data;
    rf_read_addr  = ptr_q;
    out_valid     = ov_q;
    out_data      = od_q;
    out_addr      = oa_q;
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer with a behavioural
// 32x32 register file attached to its write and read ports.
module tb_regfile_sequencer;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_dump;
  logic [4:0]  cmd_base;
  logic [4:0]  cmd_count;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_addr;
  logic        rf_write_en;
  logic [4:0]  rf_write_addr;
  logic [31:0] rf_write_data;
  logic [4:0]  rf_read_addr;
  logic [31:0] rf_read_data;
  logic        busy;
  logic        done;

  logic        init_rf;
  logic [31:0] rf     [32];
  logic [31:0] exp_rf [32];
  int nchk;
  int nerr;

  regfile_sequencer #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_dump      (cmd_dump),
    .cmd_base      (cmd_base),
    .cmd_count     (cmd_count),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_addr      (out_addr),
    .rf_write_en   (rf_write_en),
    .rf_write_addr (rf_write_addr),
    .rf_write_data (rf_write_data),
    .rf_read_addr  (rf_read_addr),
    .rf_read_data  (rf_read_data),
    .busy          (busy),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (init_rf) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'hDEAD_0000 | i;
    end else if (rf_write_en) begin
      rf[rf_write_addr] <= rf_write_data;
    end
  end

  assign rf_read_data = rf[rf_read_addr];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic dump, input logic [4:0] base,
                          input logic [4:0] cnt);
    cmd_valid = 1'b1;
    cmd_dump  = dump;
    cmd_base  = base;
    cmd_count = cnt;
    #1;
    chk("cmd_ready", cmd_ready, 1);
    step;
    cmd_valid = 1'b0;
  endtask

  task automatic run_load(input logic [4:0] base, input int n,
                          input int gap, input logic [31:0] d0,
                          input logic [31:0] dstep);
    int k;
    int cyc;
    logic v;
    logic [4:0] a;
    k = 0;
    cyc = 0;
    send_cmd(1'b0, base, 5'(n - 1));
    while (k < n && cyc < 200) begin
      v = (gap <= 1) || (cyc % gap == 0);
      a = base + 5'(k);
      in_valid = v;
      in_data  = d0 + k * dstep;
      #1;
      chk("ld_in_ready", in_ready, 1);
      chk("ld_we", rf_write_en, v);
      chk("ld_done_early", done, 0);
      if (v) begin
        chk("ld_addr", rf_write_addr, a);
        chk("ld_data", rf_write_data, in_data);
        exp_rf[a] = in_data;
        k++;
      end
      step;
      cyc++;
    end
    in_valid = 1'b0;
    if (k < n) chk("ld_timeout", 0, 1);
    #1;
    chk("ld_done", done, 1);
    chk("ld_done_we", rf_write_en, 0);
    step;
    chk("ld_done_clr", done, 0);
    chk("ld_idle", cmd_ready, 1);
  endtask

  task automatic run_dump(input logic [4:0] base, input int n,
                          input int mode, input logic intrude);
    int k;
    int cyc;
    logic [4:0] a;
    k = 0;
    cyc = 0;
    send_cmd(1'b1, base, 5'(n - 1));
    while (k < n && cyc < 200) begin
      a = base + 5'(k);
      out_ready = (mode == 0) || (cyc % 3 == 0);
      if (intrude) begin
        cmd_valid = 1'b1;
        cmd_dump  = 1'b0;
        cmd_base  = 5'd3;
        cmd_count = 5'd1;
        in_valid  = 1'b1;
        in_data   = 32'h5555_5555;
      end
      #1;
      chk("dp_we", rf_write_en, 0);
      chk("dp_cmd_ready", cmd_ready, 0);
      chk("dp_done_early", done, 0);
      if (out_valid) begin
        chk("dp_addr", out_addr, a);
        chk("dp_data", out_data, exp_rf[a]);
        if (out_ready) k++;
      end
      step;
      cyc++;
    end
    out_ready = 1'b0;
    cmd_valid = 1'b0;
    in_valid  = 1'b0;
    if (k < n) chk("dp_timeout", 0, 1);
    #1;
    chk("dp_done", done, 1);
    chk("dp_valid_clr", out_valid, 0);
    step;
    chk("dp_done_clr", done, 0);
    chk("dp_idle", busy, 0);
  endtask

  initial begin
    nchk = 0;
    nerr = 0;
    rst = 1'b0;
    init_rf = 1'b1;
    cmd_valid = 1'b0;
    cmd_dump = 1'b0;
    cmd_base = '0;
    cmd_count = '0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 32; i++) exp_rf[i] = 32'hDEAD_0000 | i;
    step;
    init_rf = 1'b0;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_we", rf_write_en, 0);
    chk("rst_ovalid", out_valid, 0);
    chk("rst_odata", out_data, 0);
    chk("rst_oaddr", out_addr, 0);
    rst = 1'b1;
    step;

    in_valid = 1'b1;
    in_data  = 32'h1234_5678;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("idle_we", rf_write_en, 0);
      chk("idle_in_ready", in_ready, 0);
      chk("idle_busy", busy, 0);
      step;
    end
    in_valid = 1'b0;

    run_load(5'd5, 3, 0, 32'hAA, 32'h11);
    chk("rb_r5", rf[5], 32'hAA);
    chk("rb_r6", rf[6], 32'hBB);
    chk("rb_r7", rf[7], 32'hCC);

    run_load(5'd30, 4, 0, 32'd1, 32'd1);
    chk("rb_r30", rf[30], 32'd1);
    chk("rb_r1", rf[1], 32'd4);
    run_dump(5'd30, 4, 0, 1'b0);

    run_dump(5'd0, 8, 1, 1'b0);

    run_load(5'd16, 5, 3, 32'h100, 32'h1);

    run_dump(5'd14, 6, 0, 1'b1);
    chk("intr_r3", rf[3], 32'hDEAD_0003);

    send_cmd(1'b0, 5'd10, 5'd3);
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h11 * (i + 1);
      exp_rf[10 + i] = in_data;
      step;
    end
    in_data = 32'h33;
    rst = 1'b0;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_we", rf_write_en, 0);
    chk("mr_in_ready", in_ready, 0);
    chk("mr_done", done, 0);
    chk("mr_cmd_ready", cmd_ready, 1);
    chk("mr_ovalid", out_valid, 0);
    chk("mr_odata", out_data, 0);
    chk("mr_oaddr", out_addr, 0);
    step;
    in_valid = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mr_no_done", done, 0);
      step;
    end
    chk("mr_r10", rf[10], 32'h11);
    chk("mr_r11", rf[11], 32'h22);
    chk("mr_r12", rf[12], 32'hDEAD_000C);
    chk("mr_r13", rf[13], 32'hDEAD_000D);

    for (int i = 0; i < 32; i++) chk("final_rf", rf[i], exp_rf[i]);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/regfile_sequencer.md
# regfile_sequencer

Bulk access engine on the initiator side of the 32 x 32-bit register file's write/read port interface. It accepts a command to either load a run of consecutive registers from a valid/ready input stream (LOAD) or read a run of consecutive registers out onto a valid/ready output stream (DUMP). It sits between the debug/boot loader path and the register file, driving `write_en`/`write_addr`/`write_data` and one read address port.

## Interface

Parameters
- `DATA_W`, 32, register width
- `ADDR_W`, 5, register address width (32 registers)

Ports
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  high only in IDLE
- `cmd_dump`  in  1  0 = LOAD, 1 = DUMP
- `cmd_base`  in  ADDR_W  first register address
- `cmd_count`  in  ADDR_W  words minus one (0 -> 1 word, 31 -> 32 words)
- `in_valid`  in  1  load data present
- `in_ready`  out  1  high only in LOAD
- `in_data`  in  DATA_W  load word
- `out_valid`  out  1  dump word present (registered)
- `out_ready`  in  1  consumer accepts dump word
- `out_data`  out  DATA_W  dump word (registered)
- `out_addr`  out  ADDR_W  register address of `out_data` (registered)
- `rf_write_en`  out  1  to register file `write_en`
- `rf_write_addr`  out  ADDR_W  to register file `write_addr`
- `rf_write_data`  out  DATA_W  to register file `write_data`
- `rf_read_addr`  out  ADDR_W  to register file `read_addr_0`
- `rf_read_data`  in  DATA_W  from register file `read_data_0`; combinational read
- `busy`  out  1  state != IDLE
- `done`  out  1  one-cycle pulse on command completion

## Operation

- States: IDLE, LOAD, DUMP, DRAIN, DONE.
- IDLE: `cmd_ready`=1. On `cmd_valid`: latch `ptr`<=`cmd_base`, `remaining`<=`cmd_count`; go LOAD if `cmd_dump`=0, else DUMP.
- LOAD: `in_ready`=1. `rf_write_en` = `in_valid` (combinational), `rf_write_addr`=`ptr`, `rf_write_data`=`in_data`; register file commits on the same edge. Per accepted word: `ptr`<=`ptr`+1 mod 32; if `remaining`==0 -> DONE, else `remaining`--.
- DUMP: `rf_read_addr`=`ptr`. Output register loads when `out_valid`=0 or (`out_valid` & `out_ready`): `out_data`<=`rf_read_data`, `out_addr`<=`ptr`, `out_valid`<=1, `ptr`++ mod 32. On loading the last word (`remaining`==0) -> DRAIN; else `remaining`--.
- DRAIN: hold `out_valid`; on `out_ready` clear `out_valid` -> DONE.
- DONE: `done`=1 for one cycle -> IDLE.
- Address arithmetic wraps modulo 32 (31 -> 0); no special treatment of register 0.
- `cmd_valid` outside IDLE is ignored (not latched). `in_valid` outside LOAD is not accepted and causes no write.
- `rf_write_en` is never asserted outside LOAD.

## Timing

- Reset (`rst`=0, asynchronous): state IDLE, `out_valid`=0, `out_data`=0, `out_addr`=0, `ptr`=0, `remaining`=0, `done`=0, `rf_write_en`=0, `in_ready`=0, `busy`=0, `cmd_ready`=1 (IDLE decode). Reset mid-command aborts immediately. Partial LOAD writes remain in the register file. No `done`.
- Command accepted at edge E0. LOAD accepts words from cycle after E0, one per cycle. With `in_valid` held high, N words are written at edges E1..EN and `done` is high in cycle N+1.
- DUMP: first word is captured at edge E1. `out_valid` is high from E1. With `out_ready` held high, one word per cycle. The last handshake is followed by DRAIN exit, then the `done` cycle.
- `out_data`/`out_addr` are stable while `out_valid`=1 and `out_ready`=0.
- Back-to-back: a new command can be accepted in the cycle after `done` (IDLE).

## Test plan

- LOAD base=5, count=2, `in_data` 0xAA,0xBB,0xCC with continuous valid -> writes r5=0xAA, r6=0xBB, r7=0xCC on 3 consecutive edges. `done` is high 1 cycle later. Register file readback matches.
- LOAD base=30, count=3, data 1,2,3,4 -> writes r30,r31,r0,r1 (wrap). DUMP base=30, count=3 -> `out_addr` 30,31,0,1 with data 1,2,3,4.
- DUMP base=0, count=7 with `out_ready` toggling 1,0,0,1,... -> each word is held stable while stalled. Exactly 8 handshakes occur, in address order 0..7, followed by one `done` pulse.
- LOAD with `in_valid` gaps (valid every 3rd cycle) -> `rf_write_en` pulses only on valid cycles. Addresses are consecutive.
- `cmd_valid` asserted during a DUMP, and `in_valid`=1 while IDLE -> no new command starts, `rf_write_en` stays 0, and the current DUMP completes unchanged.
- Assert `rst`=0 after 2 of 4 LOAD words -> all outputs are at reset values in the same cycle, `busy`=0, and no `done`. r(base), r(base+1) are written; the remaining registers are untouched.
